burst_frame_sequencer: RTL
==========================

// Module: burst_frame_sequencer
// PURPOSE
//  Sequences burst_write_wf to move one full frame from the pixel FIFO into SDRAM.
//  Splits frame_words into bursts of BURST_COUNT words plus a final remainder burst.
//  Launches each burst only when the FIFO holds enough words, and advances the address per burst.
//  Sits between the capture FIFO/HPS control registers and the burst_write_wf ctrl_* interface.
// PARAMETERS
//  ADDRESS_WIDTH          32  byte address width, matches burst_write_wf
//  LENGTH_WIDTH           32  width of frame_words and the remaining-word counter
//  BURST_COUNT             8  words per full burst (power of 2, 2..2**(BURST_WIDTH-1))
//  BURST_WIDTH             4  width of ctrl_burstcount
//  BYTE_ENABLE_WIDTH_LOG2  2  log2(bytes per word); address step = burst_words << this
//  USEDW_WIDTH             9  width of fifo_usedw
// PORTS
//  clk               in   1      system clock
//  reset_n           in   1      synchronous, active-low reset
//  start             in   1      one-cycle frame request (accepted only in IDLE)
//  frame_base        in   ADDRESS_WIDTH  byte base address of buffer 0, sampled on accepted start
//  frame_base_alt    in   ADDRESS_WIDTH  byte base of buffer 1 (used only with PINGPONG_EN)
//  frame_words       in   LENGTH_WIDTH   words per frame, sampled on accepted start
//  fifo_usedw        in   USEDW_WIDTH    words available in source FIFO
//  busy              out  1      high from accepted start until frame_done
//  frame_done        out  1      one-cycle pulse when the last burst has completed
//  done_buffer       out  1      buffer index just completed (always 0 without PINGPONG_EN)
//  ctrl_start        out  1      one-cycle launch to burst_write_wf
//  ctrl_baseaddress  out  ADDRESS_WIDTH  burst byte address, stable from ctrl_start to ctrl_busy fall
//  ctrl_burstcount   out  BURST_WIDTH    words in this burst, stable like ctrl_baseaddress
//  ctrl_busy         in   1      burst_write_wf busy
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): state IDLE; all outputs 0, including addr/count/remaining regs.
//  - FSM: IDLE -> WAIT_DATA -> LAUNCH -> WAIT_BUSY -> WAIT_DONE -> (WAIT_DATA | FRAME_DONE) -> IDLE.
//  - IDLE: start=1 latches base, frame_words, and remaining=frame_words; busy=1 next cycle.
//    Exception: if frame_words==0, go to FRAME_DONE directly with no bursts.
//  - WAIT_DATA: burst_words = min(remaining, BURST_COUNT).
//    Advance when fifo_usedw >= burst_words and ctrl_busy==0.
//  - LAUNCH: ctrl_start=1 for exactly one cycle; ctrl_burstcount=burst_words; ctrl_baseaddress=current addr.
//  - WAIT_BUSY: wait for ctrl_busy==1; WAIT_DONE: wait for ctrl_busy==0.
//  - On ctrl_busy fall: addr += burst_words<<BYTE_ENABLE_WIDTH_LOG2 (mod 2**ADDRESS_WIDTH, wrap silently);
//    remaining -= burst_words. If remaining==0 go to FRAME_DONE, else go to WAIT_DATA.
//  - FRAME_DONE: frame_done=1 for one cycle, done_buffer valid that cycle; busy drops the same cycle; -> IDLE.
//  - Latency: from accepted start to first ctrl_start is 3 cycles min (IDLE->WAIT_DATA->LAUNCH) with data present.
//  - start outside IDLE is ignored (no queueing). Changes to frame_base/frame_words mid-frame have no effect.
//  - fifo_usedw is never decremented locally; the writer consumes data, and the sequencer relies on the FIFO count.
//  - Mid-operation reset aborts immediately, with no partial-frame done pulse.
//    burst_write_wf shares the reset domain.
// CONFIGURATION
//  - PINGPONG_EN defined: a buf_sel register (reset 0) chooses frame_base (0) or frame_base_alt (1) at start.
//    buf_sel toggles in FRAME_DONE; done_buffer = buf_sel of the completed frame.
//  - PINGPONG_EN undefined: frame_base_alt is unused and always frame_base is used; done_buffer tied 0.
// STRUCTURE
//  - Shared package burst_pkg: FSM state enum (IDLE, WAIT_DATA, LAUNCH, WAIT_BUSY, WAIT_DONE, FRAME_DONE),
//    plus BURST_COUNT/BURST_WIDTH/BYTE_ENABLE_WIDTH_LOG2 defaults used by burst_write_wf.
//  - Single module; the min/step arithmetic is inline, and there is no sub-module.
// TESTING
//  Bench: burst_write_wf as DUT companion with master_waitrequest=0, or a ctrl_busy model of 8+2 cycles.
//  1. frame_words=32, base=0x38000000, usedw=511 -> 4 bursts of 8 at 0x38000000/20/40/60; one frame_done.
//  2. frame_words=20 -> bursts 8,8,4 at +0x00/+0x20/+0x40; last ctrl_burstcount=4; frame_done after third.
//  3. usedw=5 held for 50 cycles, then 8 -> no ctrl_start while 5; launch within 2 cycles of usedw=8.
//  4. frame_words=0 -> frame_done pulse 2 cycles after start; ctrl_start never asserted.
//  5. start pulsed again mid-frame, then reset_n=0 during WAIT_DONE -> second start ignored;
//     after reset all outputs 0 and no frame_done.
//  6. PINGPONG_EN, base=0x38000000, alt=0x38100000, three frames of 16 words ->
//     first addresses 0x38000000, 0x38100000, 0x38000000; done_buffer 0,1,0.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared definitions for the burst writer and its frame sequencer.
package burst_pkg;

  localparam int unsigned BURST_COUNT_DEF            = 8;
  localparam int unsigned BURST_WIDTH_DEF            = 4;
  localparam int unsigned BYTE_ENABLE_WIDTH_LOG2_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    FRAME_DONE
  } seq_state_t;

endpackage

// File: rtl/burst_frame_sequencer.sv
// Moves one frame from the pixel FIFO to SDRAM as a run of bursts via burst_write_wf.
// Optional PINGPONG_EN alternates between frame_base and frame_base_alt per frame.
module burst_frame_sequencer
  import burst_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH          = 32,
  parameter int unsigned LENGTH_WIDTH           = 32,
  parameter int unsigned BURST_COUNT            = BURST_COUNT_DEF,
  parameter int unsigned BURST_WIDTH            = BURST_WIDTH_DEF,
  parameter int unsigned BYTE_ENABLE_WIDTH_LOG2 = BYTE_ENABLE_WIDTH_LOG2_DEF,
  parameter int unsigned USEDW_WIDTH            = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] frame_base,
  input  logic [ADDRESS_WIDTH-1:0] frame_base_alt,
  input  logic [LENGTH_WIDTH-1:0]  frame_words,
  input  logic [USEDW_WIDTH-1:0]   fifo_usedw,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     done_buffer,
  output logic                     ctrl_start,
  output logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
  output logic [BURST_WIDTH-1:0]   ctrl_burstcount,
  input  logic                     ctrl_busy
);

  localparam int unsigned CMP_W = (USEDW_WIDTH > BURST_WIDTH) ? USEDW_WIDTH : BURST_WIDTH;

  seq_state_t                state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [BURST_WIDTH-1:0]    burst_q, burst_d;
  logic [LENGTH_WIDTH-1:0]   remaining_q, remaining_d;
  logic                      busy_d, frame_done_d, done_buffer_d, ctrl_start_d;
  logic [BURST_WIDTH-1:0]    burst_words_c;
  logic                      data_ok_c;
  logic [ADDRESS_WIDTH-1:0]  base_sel_c;
  logic                      done_sel_c;

`ifdef PINGPONG_EN
  logic buf_sel_q;

  // Buffer selector flips once per completed frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_sel_q <= 1'b0;
    end else if (state_q == FRAME_DONE) begin
      buf_sel_q <= ~buf_sel_q;
    end
  end

  assign base_sel_c = buf_sel_q ? frame_base_alt : frame_base;
  assign done_sel_c = buf_sel_q;
`else
  logic unused_alt;

  assign unused_alt = ^frame_base_alt;
  assign base_sel_c = frame_base;
  assign done_sel_c = 1'b0;
`endif

  // Size of the next burst and whether the FIFO already holds it
  assign burst_words_c = (remaining_q < LENGTH_WIDTH'(BURST_COUNT)) ?
                         BURST_WIDTH'(remaining_q) : BURST_WIDTH'(BURST_COUNT);
  assign data_ok_c     = CMP_W'(fifo_usedw) >= CMP_W'(burst_words_c);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    burst_d     = burst_q;
    remaining_d = remaining_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_sel_c;
          remaining_d = frame_words;
          state_d     = (frame_words == '0) ? FRAME_DONE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_ok_c && !ctrl_busy) begin
          burst_d = burst_words_c;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ctrl_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!ctrl_busy) begin
          addr_d      = addr_q + (ADDRESS_WIDTH'(burst_q) << BYTE_ENABLE_WIDTH_LOG2);
          remaining_d = remaining_q - LENGTH_WIDTH'(burst_q);
          state_d     = (remaining_d == '0) ? FRAME_DONE : WAIT_DATA;
        end
      end
      FRAME_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs decoded from the next state so they register alongside it
    busy_d        = (state_d == WAIT_DATA) || (state_d == LAUNCH) ||
                    (state_d == WAIT_BUSY) || (state_d == WAIT_DONE);
    frame_done_d  = (state_d == FRAME_DONE);
    done_buffer_d = (state_d == FRAME_DONE) ? done_sel_c : 1'b0;
    ctrl_start_d  = (state_d == LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      burst_q     <= '0;
      remaining_q <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      done_buffer <= 1'b0;
      ctrl_start  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      remaining_q <= remaining_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
      done_buffer <= done_buffer_d;
      ctrl_start  <= ctrl_start_d;
    end
  end

  assign ctrl_baseaddress = addr_q;
  assign ctrl_burstcount  = burst_q;

endmodule
